mul_rr_scheduler: RTL

//  Shares one iterative 8x8 shift-add multiply datapath between NREQ requesters.

---
 rtl/mul_rr_scheduler_pkg.sv | 21 ++
 rtl/mul_rr_scheduler_if.sv | 32 +++
 rtl/mul_rr_scheduler_shift_add_core.sv | 53 +++++
 rtl/mul_rr_scheduler.sv | 101 ++++++++++
 4 files changed

// File: rtl/mul_rr_scheduler_pkg.sv
// Shared definitions for the round-robin multiply scheduler: FSM encodings,
// default sizes and a constant clog2 helper.
package mul_rr_scheduler_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int f_clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mul_rr_scheduler_if.sv
// Request/response bundle between the client units and the multiply scheduler.
// The scheduler takes the slave side; clients (or a bench) take the master side.
interface mul_rr_scheduler_if
  import mul_rr_scheduler_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) ();

  localparam int IDW = f_clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [2*WIDTH-1:0]    resp_product;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_product, busy
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_product, busy
  );

endinterface

// File: rtl/mul_rr_scheduler_shift_add_core.sv
// Iterative WIDTH x WIDTH unsigned shift-add multiplier: one step per clock,
// o_done marks the step that produces the final product on o_product.
module shift_add_core
  import mul_rr_scheduler_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CNTW = f_clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(WIDTH);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(1);

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNTW-1:0]    r_cnt;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_nxt;

  // The extra sum bit carries into the top of the accumulator so 255*255 stays exact.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
  assign w_acc_nxt = r_b[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

  assign o_done    = (r_cnt == CNT_LAST);
  assign o_product = w_acc_nxt;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= '0;
      r_cnt <= CNT_LOAD;
    end else if (r_cnt != '0) begin
      r_acc <= w_acc_nxt;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt - CNT_LAST;
    end
  end

endmodule

// File: rtl/mul_rr_scheduler.sv
// Round-robin front end sharing one shift-add multiplier between NREQ requesters,
// with a single buffered response tagged by requester id.
//   state   | meaning
//   ST_IDLE | arbitrating; req_ready carries the one-hot grant
//   ST_EXEC | multiplier stepping, WIDTH cycles
//   ST_DONE | response held until resp_ready
module mul_rr_scheduler
  import mul_rr_scheduler_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             areset,
  mul_rr_scheduler_if.slave bus
);

  localparam int IDW = f_clog2(NREQ);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_resp_id;
  logic [2*WIDTH-1:0] r_resp_product;
  logic               r_resp_valid;
  logic [NREQ-1:0]    w_grant;
  logic [IDW-1:0]     w_gidx;
  logic               w_found;
  logic               w_accept;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_core_done;
  logic [2*WIDTH-1:0] w_core_product;

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && bus.req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_gidx  = IDW'((int'(r_ptr) + k) % NREQ);
      end
    end
    w_grant[w_gidx] = w_found;
  end

  assign w_accept = (r_state == ST_IDLE) && w_found;
  assign w_a      = bus.req_a[int'(w_gidx)*WIDTH +: WIDTH];
  assign w_b      = bus.req_b[int'(w_gidx)*WIDTH +: WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)       w_state_nxt = ST_EXEC;
      ST_EXEC: if (w_core_done)    w_state_nxt = ST_DONE;
      ST_DONE: if (bus.resp_ready) w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state        <= ST_IDLE;
      r_ptr          <= IDW'(NREQ - 1);
      r_resp_id      <= '0;
      r_resp_product <= '0;
      r_resp_valid   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_ptr     <= w_gidx;
        r_resp_id <= w_gidx;
      end
      if ((r_state == ST_EXEC) && w_core_done) begin
        r_resp_product <= w_core_product;
        r_resp_valid   <= 1'b1;
      end else if ((r_state == ST_DONE) && bus.resp_ready) begin
        r_resp_valid   <= 1'b0;
      end
    end
  end

  shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .areset    (areset),
    .i_start   (w_accept),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_done    (w_core_done),
    .o_product (w_core_product)
  );

  assign bus.req_ready    = (r_state == ST_IDLE) ? w_grant : '0;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_id      = r_resp_id;
  assign bus.resp_product = r_resp_product;
  assign bus.busy         = (r_state != ST_IDLE);

endmodule
